uart_rx: RTL

Serial receive stage for the UART path: samples the asynchronous `serial_rx` line, recovers 8N1 frames (LSB first), and presents each byte on a valid/ready output register to the downstream consumer. It is the counterpart of the transmitter and shares its timebase scheme: a free-running clock divider producing an oversample tick. Framing, overrun and optional parity errors are reported as single-cycle pulses.

---
 rtl/uart_rx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with a valid/ready byte register and error pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames and check even parity.
module uart_rx #(
   parameter int CLOCK_DIV  = 13,
   parameter int OVERSAMPLE = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       serial_rx,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_error,
   output logic       overrun,
   output logic       parity_error
);
   localparam int DW = $clog2(CLOCK_DIV + 1);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLOCK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE   = DW'(1);
   localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SAMP_ONE  = SW'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_HIGH = 3'd5
   } state_t;

   logic          sync1_q, rx_s_q;
   logic [DW-1:0] div_q;
   logic          tick_s, mid_s, complete_s;
   state_t        state_q, state_d;
   logic [SW-1:0] samp_q, samp_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    byte_q, byte_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic          perr_q, perr_d;
   logic          par_bad_q, par_bad_d;
`endif

   assign tick_s = (div_q == DIV_LAST);
   assign mid_s  = tick_s && (samp_q == SAMP_MID);

   // Input synchroniser and free-running oversample divider.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         div_q   <= {DW{1'b0}};
      end else begin
         sync1_q <= serial_rx;
         rx_s_q  <= sync1_q;
         if (tick_s) div_q <= {DW{1'b0}};
         else        div_q <= div_q + DIV_ONE;
      end
   end

   // Frame FSM, sample counter, shift register and output register next state.
   always_comb begin
      state_d    = state_q;
      samp_d     = samp_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      byte_d     = byte_q;
      ferr_d     = 1'b0;
      ovr_d      = 1'b0;
      complete_s = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d     = 1'b0;
      par_bad_d  = par_bad_q;
`endif
      if (valid_q && rx_ready) valid_d = 1'b0;
      else                     valid_d = valid_q;

      if (tick_s) begin
         if (samp_q == SAMP_LAST) samp_d = {SW{1'b0}};
         else                     samp_d = samp_q + SAMP_ONE;
      end else begin
         samp_d = samp_q;
      end

      case (state_q)
         S_IDLE: begin
            samp_d = {SW{1'b0}};
            if (tick_s && !rx_s_q) state_d = S_START;
            else                   state_d = S_IDLE;
         end
         S_START: begin
            if (mid_s) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  // Counter now sits one tick past mid-bit, so later mid samples land a full bit apart.
                  samp_d  = SAMP_MID + SAMP_ONE;
                  idx_d   = 3'd0;
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (mid_s) begin
               shreg_d[idx_q] = rx_s_q;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (mid_s) begin
               par_bad_d = ^{shreg_q, rx_s_q};
               state_d   = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            if (mid_s) begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad_q) perr_d = 1'b1;
                  else           complete_s = 1'b1;
`else
                  complete_s = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         S_WAIT_HIGH: begin
            if (tick_s && rx_s_q) state_d = S_IDLE;
            else                  state_d = S_WAIT_HIGH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (complete_s) begin
         if (!valid_q || rx_ready) begin
            byte_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else begin
         ovr_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         samp_q    <= {SW{1'b0}};
         idx_q     <= 3'd0;
         shreg_q   <= 8'h00;
         byte_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         samp_q    <= samp_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
         perr_q    <= perr_d;
         par_bad_q <= par_bad_d;
`endif
      end
   end

   assign rx_byte       = byte_q;
   assign rx_valid      = valid_q;
   assign framing_error = ferr_q;
   assign overrun       = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error  = perr_q;
`else
   assign parity_error  = 1'b0;
`endif

endmodule
